// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a 512x32 single-port RAM (IDLE/ACCESS/ACK).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to port 0.
module ram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_wr,
  input  logic        p1_wr,
  input  logic [8:0]  p0_addr,
  input  logic [8:0]  p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_gnt;
  logic        r_wr;
  logic [8:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        w_any;
  logic        w_pick;
  logic        w_last;

  assign w_any  = p0_req | p1_req;
  assign w_last = (r_state == ACCESS) && (r_cnt == LAST);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // r_last holds the most recently granted port; reset value favours port 0
  logic r_last;

  assign w_pick = (p0_req && p1_req) ? ~r_last : p1_req;

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE && w_any) begin
      r_last <= w_pick;
    end
  end
`else
  assign w_pick = ~p0_req;
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  if (r_cnt == LAST) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_cnt    <= '0;
      r_gnt    <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_cnt   <= '0;
        r_gnt   <= w_pick;
        r_wr    <= w_pick ? p1_wr    : p0_wr;
        r_addr  <= w_pick ? p1_addr  : p0_addr;
        r_wdata <= w_pick ? p1_wdata : p0_wdata;
      end
      if (r_state == ACCESS) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_last && !r_wr) begin
        if (r_gnt) r_rdata1 <= mem_rdata;
        else       r_rdata0 <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    unique case (r_state)
      ACCESS: begin
        mem_read  = ~r_wr;
        mem_write = r_wr;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      ACK: begin
        p0_ack = ~r_gnt;
        p1_ack = r_gnt;
      end
      default: ;
    endcase
  end

  assign p0_rdata = r_rdata0;
  assign p1_rdata = r_rdata1;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, corner sequences, random traffic.
// Instance a uses WAIT_CYCLES=1, instance b uses WAIT_CYCLES=4.
module tb_ram_arbiter;

  localparam int WA = 1;
  localparam int WB = 4;

  logic        clk = 1'b0;
  logic        clear;
  logic        p0_req, p1_req, p0_wr, p1_wr;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;

  logic        p0_ack_a, p1_ack_a, mem_read_a, mem_write_a, busy_a;
  logic [31:0] p0_rdata_a, p1_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [8:0]  mem_addr_a;
  logic        p0_ack_b, p1_ack_b, mem_read_b, mem_write_b, busy_b;
  logic [31:0] p0_rdata_b, p1_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [8:0]  mem_addr_b;

  logic [31:0] mem_a [0:511];
  logic [31:0] mem_b [0:511];
  logic        mem_clr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WAIT_CYCLES(WA)) u_dut_a (
    .clock(clk), .clear(clear),
    .p0_req(p0_req), .p1_req(p1_req), .p0_wr(p0_wr), .p1_wr(p1_wr),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack_a), .p1_ack(p1_ack_a),
    .p0_rdata(p0_rdata_a), .p1_rdata(p1_rdata_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  ram_arbiter #(.WAIT_CYCLES(WB)) u_dut_b (
    .clock(clk), .clear(clear),
    .p0_req(p0_req), .p1_req(p1_req), .p0_wr(p0_wr), .p1_wr(p1_wr),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack_b), .p1_ack(p1_ack_b),
    .p0_rdata(p0_rdata_b), .p1_rdata(p1_rdata_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  // RAM models: combinational read, write on rising edge
  assign mem_rdata_a = mem_a[mem_addr_a];
  assign mem_rdata_b = mem_b[mem_addr_b];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_a[5] <= 32'hDEADBEEF;
      mem_b[5] <= 32'hDEADBEEF;
    end else begin
      if (mem_write_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_write_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
  end

  typedef struct {
    logic        pt;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    clear  = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic set_port(input bit pt, input logic wr,
                          input logic [8:0] ad, input logic [31:0] wd);
    if (pt) begin
      p1_wr = wr; p1_addr = ad; p1_wdata = wd; p1_req = 1'b1;
    end else begin
      p0_wr = wr; p0_addr = ad; p0_wdata = wd; p0_req = 1'b1;
    end
  endtask

  // One transaction on instance a; returns ack latency in edges after request
  task automatic do_txn(input bit pt, input logic wr, input logic [8:0] ad,
                        input logic [31:0] wd, output int lat,
                        output int nstb, output int nbad,
                        output logic [31:0] rd);
    lat = 0; nstb = 0; nbad = 0; rd = '0;
    set_port(pt, wr, ad, wd);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_read_a || mem_write_a) begin
        nstb++;
        if (mem_addr_a !== ad || mem_write_a !== wr || mem_read_a !== !wr ||
            (wr && mem_wdata_a !== wd)) nbad++;
      end
      if (pt ? p0_ack_a : p1_ack_a) nbad++;
      if (pt ? p1_ack_a : p0_ack_a) begin
        lat = k;
        rd  = pt ? p1_rdata_a : p0_rdata_a;
        break;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
  endtask

  // Random-phase reference state
  logic [31:0] ref_mem [0:511];
  bit          pend [2];
  logic        rwr [2];
  logic [8:0]  radr [2];
  logic [31:0] rwd [2];
  logic [31:0] exp_rd [2];
  int          age [2];
  int          cool [2];

  initial begin
    int lat, nstb, nbad, nack, first;
    logic [31:0] rd;
    int cnt [2];
    int cl [2];
    int order [$];
    bit ack, ok;

    tbl[0] = '{1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h00000000};
    tbl[1] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
    tbl[2] = '{1'b0, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 9'h000, 32'hA5A5A5A5, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 1'b0, 9'h000, 32'h0,        32'hA5A5A5A5};
    tbl[5] = '{1'b1, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF};
    tbl[6] = '{1'b0, 1'b1, 9'h005, 32'h00000000, 32'hA5A5A5A5};
    tbl[7] = '{1'b1, 1'b0, 9'h005, 32'h0,        32'h00000000};

    p0_wr = 0; p1_wr = 0; p0_addr = 0; p1_addr = 0;
    p0_wdata = 0; p1_wdata = 0;
    mem_clr = 1'b1;
    clear = 1'b0; p0_req = 0; p1_req = 0;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;

    chk("rst_busy",   {31'h0, busy_a}, 0);
    chk("rst_strobe", {30'h0, mem_read_a, mem_write_a}, 0);
    chk("rst_ack",    {30'h0, p0_ack_a, p1_ack_a}, 0);
    chk("rst_addr",   {23'h0, mem_addr_a}, 0);
    chk("rst_wdata",  mem_wdata_a, 0);
    chk("rst_rdata",  p0_rdata_a | p1_rdata_a, 0);
    clear = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].pt, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
             lat, nstb, nbad, rd);
      chk($sformatf("vec%0d_latency", i), lat, WA + 1);
      chk($sformatf("vec%0d_strobes", i), nstb, WA);
      chk($sformatf("vec%0d_bus", i), nbad, 0);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
    end

    // Address change mid-access on the 4-wait instance
    set_port(1'b0, 1'b0, 9'h010, 32'h0);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) p0_addr = 9'h020;
      if (mem_read_b || mem_write_b) chk("hold_addr", {23'h0, mem_addr_b}, 32'h010);
      chk("hold_busy", {31'h0, busy_b}, 1);
      if (p0_ack_b) begin
        lat = k;
        break;
      end
    end
    p0_req = 1'b0;
    chk("hold_latency", lat, WB + 1);
    repeat (6) @(negedge clk);
    chk("idle_busy", {31'h0, busy_b}, 0);

    // Reset in the second ACCESS cycle of the 4-wait instance
    set_port(1'b0, 1'b1, 9'h033, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("abort_busy",   {31'h0, busy_b}, 0);
    chk("abort_strobe", {30'h0, mem_read_b, mem_write_b}, 0);
    chk("abort_ack",    {30'h0, p0_ack_b, p1_ack_b}, 0);
    chk("abort_addr",   {23'h0, mem_addr_b}, 0);
    chk("abort_wdata",  mem_wdata_b, 0);
    chk("abort_rdata",  p0_rdata_b | p1_rdata_b, 0);
    chk("abort_wrote",  mem_b[9'h033], 32'hCAFEF00D);
    p0_req = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    nack = 0;
    repeat (8) begin
      @(negedge clk);
      if (p0_ack_b || p1_ack_b) nack++;
    end
    chk("abort_no_ack", nack, 0);

    // Contention: both request together, each re-requests two cycles after ack
    do_reset();
    cnt[0] = 0; cnt[1] = 0; cl[0] = 0; cl[1] = 0;
    set_port(1'b0, 1'b0, 9'h010, 32'h0);
    set_port(1'b1, 1'b0, 9'h011, 32'h0);
    for (int c = 0; c < 200 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
      @(negedge clk);
      chk("cont_excl", {31'h0, mem_read_a & mem_write_a}, 0);
      for (int p = 0; p < 2; p++) begin
        ack = p ? p1_ack_a : p0_ack_a;
        if (ack) begin
          order.push_back(p);
          cnt[p]++;
          cl[p] = 2;
          if (p) p1_req = 1'b0; else p0_req = 1'b0;
        end else if (cl[p] > 0) begin
          cl[p]--;
          if (cl[p] == 0 && cnt[p] < 4) begin
            if (p) p1_req = 1'b1; else p0_req = 1'b1;
          end
        end
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("cont_count", order.size(), 8);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("cont_order%0d", i), order[i], i % 2);
    @(negedge clk);

    // After a lone p0 grant, a simultaneous pair shows the arbitration policy
    do_txn(1'b0, 1'b0, 9'h005, 32'h0, lat, nstb, nbad, rd);
    chk("pol_solo_lat", lat, WA + 1);
    set_port(1'b0, 1'b0, 9'h001, 32'h0);
    set_port(1'b1, 1'b0, 9'h002, 32'h0);
    first = -1;
    nack = 0;
    for (int c = 0; c < 30 && nack < 2; c++) begin
      @(negedge clk);
      if (p0_ack_a) begin
        if (first < 0) first = 0;
        nack++;
        p0_req = 1'b0;
      end
      if (p1_ack_a) begin
        if (first < 0) first = 1;
        nack++;
        p1_req = 1'b0;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("pol_both_served", nack, 2);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    chk("pol_first", first, 1);
`else
    chk("pol_first", first, 0);
`endif

    // Random traffic against a serialized-memory reference
    do_reset();
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    ref_mem[5] = 32'hDEADBEEF;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; exp_rd[p] = 0; age[p] = 0; cool[p] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c >= 2500 && !pend[0] && !pend[1]) break;
      chk("rnd_excl", {31'h0, mem_read_a & mem_write_a}, 0);
      chk("rnd_one_ack", {31'h0, p0_ack_a & p1_ack_a}, 0);
      if (mem_read_a || mem_write_a) begin
        ok = (pend[0] && mem_addr_a == radr[0] && mem_write_a == rwr[0]) ||
             (pend[1] && mem_addr_a == radr[1] && mem_write_a == rwr[1]);
        chk("rnd_strobe_addr", {31'h0, ok}, 1);
      end
      for (int p = 0; p < 2; p++) begin
        ack = p ? p1_ack_a : p0_ack_a;
        if (ack) begin
          chk($sformatf("rnd_ack_pending_p%0d", p), {31'h0, pend[p]}, 1);
          if (rwr[p]) ref_mem[radr[p]] = rwd[p];
          else        exp_rd[p] = ref_mem[radr[p]];
          chk($sformatf("rnd_rdata_p%0d", p),
              p ? p1_rdata_a : p0_rdata_a, exp_rd[p]);
          pend[p] = 0;
          cool[p] = 2;
          if (p) p1_req = 1'b0; else p0_req = 1'b0;
        end else if (pend[p]) begin
          age[p]++;
          if (age[p] > 20) begin
            chk($sformatf("rnd_timeout_p%0d", p), age[p], 20);
            pend[p] = 0;
            if (p) p1_req = 1'b0; else p0_req = 1'b0;
          end
        end else if (cool[p] > 0) begin
          cool[p]--;
        end else if (c < 2500 && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          age[p]  = 0;
          rwr[p]  = 1'($urandom_range(0, 1));
          radr[p] = ($urandom_range(0, 1) == 1) ? 9'h1F8 : 9'h000;
          radr[p] = radr[p] | 9'($urandom_range(0, 7));
          rwd[p]  = $urandom;
          set_port(p[0], rwr[p], radr[p], rwd[p]);
        end
      end
    end
    chk("rnd_drained", {30'h0, pend[0], pend[1]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
